// File: rtl/aw_channel_arbiter_2m.sv
// Write-address arbiter for a 2-master interconnect.
// Chooses one master per AW transaction (QoS first, then round-robin),
// returns awready only to the winner, and records the grant order in a
// small FIFO so the W-channel mux can forward write bursts in AW order.
module aw_channel_arbiter_2m #(
  parameter int Order_depth = 4,
  parameter bit Qos_enable  = 1'b1
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       S00_AXI_awvalid,
  input  logic [3:0] S00_AXI_awqos,
  input  logic       S01_AXI_awvalid,
  input  logic [3:0] S01_AXI_awqos,
  input  logic       M_AXI_awready,
  input  logic       W_last_hs,
  output logic [1:0] Selected_Slave,
  output logic       Grant_valid,
  output logic       S00_AXI_awready,
  output logic       S01_AXI_awready,
  output logic [1:0] W_Sel,
  output logic       W_Sel_valid,
  output logic       Order_err
);

  localparam int PTR_W = (Order_depth > 1) ? $clog2(Order_depth) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t     state_reg;
  logic       sel_reg;
  logic       last_winner_reg;
  logic       grant_valid_reg;
  logic       order_err_reg;

  logic             fifo_mem [Order_depth];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic fifo_full;
  logic fifo_empty;
  logic winner_awvalid;
  logic handshake;
  logic push;
  logic pop;
  logic start_grant;
  logic next_winner;

  assign fifo_full      = (count_reg == CNT_W'(Order_depth));
  assign fifo_empty     = (count_reg == '0);
  assign winner_awvalid = sel_reg ? S01_AXI_awvalid : S00_AXI_awvalid;
  assign handshake      = grant_valid_reg & winner_awvalid & M_AXI_awready;
  assign push           = handshake;
  assign pop            = W_last_hs & ~fifo_empty;
  assign start_grant    = (state_reg == IDLE) & (S00_AXI_awvalid | S01_AXI_awvalid) & ~fifo_full;

  // Winner selection: lone requester wins, else higher QoS, else the master that did not win last.
  always_comb begin
    next_winner = ~last_winner_reg;
    if (S00_AXI_awvalid && !S01_AXI_awvalid) begin
      next_winner = 1'b0;
    end else if (S01_AXI_awvalid && !S00_AXI_awvalid) begin
      next_winner = 1'b1;
    end else if (Qos_enable && (S00_AXI_awqos != S01_AXI_awqos)) begin
      next_winner = (S01_AXI_awqos > S00_AXI_awqos);
    end
  end

  // Grant FSM: IDLE registers a winner, GRANTED holds it until the winner's AW handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg       <= IDLE;
      sel_reg         <= 1'b0;
      grant_valid_reg <= 1'b0;
      last_winner_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_grant) begin
            state_reg       <= GRANTED;
            sel_reg         <= next_winner;
            grant_valid_reg <= 1'b1;
          end
        end
        GRANTED: begin
          if (handshake) begin
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            last_winner_reg <= sel_reg;
          end
        end
        default: begin
          state_reg       <= IDLE;
          grant_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Order FIFO storage: one master ID per accepted AW; no reset needed since count gates reads.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= sel_reg;
    end
  end

  // Order FIFO pointers and occupancy; pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky error: a W burst finished with no AW recorded to own it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      order_err_reg <= 1'b0;
    end else if (W_last_hs && fifo_empty) begin
      order_err_reg <= 1'b1;
    end
  end

  assign Selected_Slave  = {1'b0, sel_reg};
  assign Grant_valid     = grant_valid_reg;
  assign S00_AXI_awready = grant_valid_reg & ~sel_reg & M_AXI_awready;
  assign S01_AXI_awready = grant_valid_reg &  sel_reg & M_AXI_awready;
  assign W_Sel           = {1'b0, fifo_empty ? 1'b0 : fifo_mem[rd_ptr_reg]};
  assign W_Sel_valid     = ~fifo_empty;
  assign Order_err       = order_err_reg;

endmodule

// File: tb/tb_aw_channel_arbiter_2m.sv
// Self-checking bench for aw_channel_arbiter_2m: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_aw_channel_arbiter_2m;

  localparam int DEPTH = 4;
  localparam bit QOS   = 1'b1;

  logic       ACLK;
  logic       ARESETN;
  logic       S00_AXI_awvalid;
  logic [3:0] S00_AXI_awqos;
  logic       S01_AXI_awvalid;
  logic [3:0] S01_AXI_awqos;
  logic       M_AXI_awready;
  logic       W_last_hs;
  logic [1:0] Selected_Slave;
  logic       Grant_valid;
  logic       S00_AXI_awready;
  logic       S01_AXI_awready;
  logic [1:0] W_Sel;
  logic       W_Sel_valid;
  logic       Order_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_granted;
  bit m_sel;
  bit m_last;
  bit m_err;
  int m_q[$];
  int grant_seq[$];

  aw_channel_arbiter_2m #(.Order_depth(DEPTH), .Qos_enable(QOS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S00_AXI_awvalid(S00_AXI_awvalid), .S00_AXI_awqos(S00_AXI_awqos),
    .S01_AXI_awvalid(S01_AXI_awvalid), .S01_AXI_awqos(S01_AXI_awqos),
    .M_AXI_awready(M_AXI_awready), .W_last_hs(W_last_hs),
    .Selected_Slave(Selected_Slave), .Grant_valid(Grant_valid),
    .S00_AXI_awready(S00_AXI_awready), .S01_AXI_awready(S01_AXI_awready),
    .W_Sel(W_Sel), .W_Sel_valid(W_Sel_valid), .Order_err(Order_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic void model_reset();
    m_granted = 1'b0;
    m_sel     = 1'b0;
    m_last    = 1'b1;
    m_err     = 1'b0;
    m_q.delete();
  endfunction

  // One clock of the arbitration rules, evaluated on the inputs present at the edge.
  function automatic void model_step();
    bit hs;
    bit can_grant;
    bit w;
    hs = m_granted && (m_sel ? S01_AXI_awvalid : S00_AXI_awvalid) && M_AXI_awready;
    can_grant = !m_granted && (S00_AXI_awvalid || S01_AXI_awvalid) && (m_q.size() < DEPTH);
    if (W_last_hs) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else void'(m_q.pop_front());
    end
    if (hs) begin
      m_q.push_back(int'(m_sel));
      m_last    = m_sel;
      m_granted = 1'b0;
    end
    if (can_grant) begin
      if (S00_AXI_awvalid && !S01_AXI_awvalid) w = 1'b0;
      else if (S01_AXI_awvalid && !S00_AXI_awvalid) w = 1'b1;
      else if (QOS && S00_AXI_awqos != S01_AXI_awqos) w = (S01_AXI_awqos > S00_AXI_awqos);
      else w = !m_last;
      m_granted = 1'b1;
      m_sel     = w;
    end
  endfunction

  task automatic clear_inputs();
    S00_AXI_awvalid = 1'b0; S00_AXI_awqos = 4'd0;
    S01_AXI_awvalid = 1'b0; S01_AXI_awqos = 4'd0;
    M_AXI_awready   = 1'b0; W_last_hs     = 1'b0;
  endtask

  task automatic advance();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  // Runs until n AW handshakes are seen or the cycle budget expires.
  task automatic collect_grants(input int n, input int max_cycles, input bit drop);
    bit hs_now;
    bit who;
    grant_seq.delete();
    for (int c = 0; c < max_cycles && grant_seq.size() < n; c++) begin
      @(negedge ACLK);
      who    = Selected_Slave[0];
      hs_now = Grant_valid && M_AXI_awready && (who ? S01_AXI_awvalid : S00_AXI_awvalid);
      advance();
      if (hs_now) begin
        grant_seq.push_back(int'(who));
        $display("aw handshake master=%0d", who);
        if (drop) begin
          if (who) S01_AXI_awvalid = 1'b0;
          else     S00_AXI_awvalid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge ACLK);
    total++;
    if ({Selected_Slave, Grant_valid, S00_AXI_awready, S01_AXI_awready, W_Sel, W_Sel_valid, Order_err} !== 9'd0)
      begin bad++; $display("FAIL reset_values got=%b expected=%b",
        {Selected_Slave, Grant_valid, S00_AXI_awready, S01_AXI_awready, W_Sel, W_Sel_valid, Order_err}, 9'd0); end
    apply_reset();
    @(negedge ACLK);
    total++;
    if (Grant_valid !== 1'b0 || W_Sel_valid !== 1'b0)
      begin bad++; $display("FAIL reset_release gv=%b wsv=%b expected 0 0", Grant_valid, W_Sel_valid); end
  endtask

  task automatic test_single();
    apply_reset();
    S00_AXI_awvalid = 1'b1; S00_AXI_awqos = 4'd0; M_AXI_awready = 1'b1;
    @(negedge ACLK);
    total++;
    if (Grant_valid !== 1'b0) begin bad++; $display("FAIL single_no_early_grant got=%b expected=0", Grant_valid); end
    advance();
    @(negedge ACLK);
    total++;
    if (Grant_valid !== 1'b1 || Selected_Slave !== 2'd0)
      begin bad++; $display("FAIL single_grant gv=%b sel=%0d expected 1 0", Grant_valid, Selected_Slave); end
    total++;
    if (S00_AXI_awready !== 1'b1 || S01_AXI_awready !== 1'b0)
      begin bad++; $display("FAIL single_awready r0=%b r1=%b expected 1 0", S00_AXI_awready, S01_AXI_awready); end
    advance();
    S00_AXI_awvalid = 1'b0;
    @(negedge ACLK);
    total++;
    if (S00_AXI_awready !== 1'b0 || Grant_valid !== 1'b0)
      begin bad++; $display("FAIL single_release r0=%b gv=%b expected 0 0", S00_AXI_awready, Grant_valid); end
    total++;
    if (W_Sel !== 2'd0 || W_Sel_valid !== 1'b1)
      begin bad++; $display("FAIL single_order wsel=%0d wsv=%b expected 0 1", W_Sel, W_Sel_valid); end
    W_last_hs = 1'b1;
    advance();
    W_last_hs = 1'b0;
    @(negedge ACLK);
    total++;
    if (W_Sel_valid !== 1'b0) begin bad++; $display("FAIL single_drain wsv=%b expected 0", W_Sel_valid); end
  endtask

  task automatic test_qos();
    apply_reset();
    S00_AXI_awvalid = 1'b1; S00_AXI_awqos = 4'd5;
    S01_AXI_awvalid = 1'b1; S01_AXI_awqos = 4'd10;
    M_AXI_awready = 1'b1;
    collect_grants(2, 12, 1'b1);
    total++;
    if (grant_seq.size() != 2) begin bad++; $display("FAIL qos_count got=%0d expected=2", grant_seq.size()); end
    else if (grant_seq[0] != 1 || grant_seq[1] != 0)
      begin bad++; $display("FAIL qos_order got=%0d,%0d expected=1,0", grant_seq[0], grant_seq[1]); end
    @(negedge ACLK);
    total++;
    if (W_Sel !== 2'd1 || W_Sel_valid !== 1'b1)
      begin bad++; $display("FAIL qos_fifo_head wsel=%0d wsv=%b expected 1 1", W_Sel, W_Sel_valid); end
    W_last_hs = 1'b1; advance(); W_last_hs = 1'b0;
    @(negedge ACLK);
    total++;
    if (W_Sel !== 2'd0 || W_Sel_valid !== 1'b1)
      begin bad++; $display("FAIL qos_fifo_second wsel=%0d wsv=%b expected 0 1", W_Sel, W_Sel_valid); end
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 1, 0, 1};
    apply_reset();
    S00_AXI_awvalid = 1'b1; S00_AXI_awqos = 4'd3;
    S01_AXI_awvalid = 1'b1; S01_AXI_awqos = 4'd3;
    M_AXI_awready = 1'b1;
    collect_grants(4, 20, 1'b0);
    S00_AXI_awvalid = 1'b0; S01_AXI_awvalid = 1'b0;
    total++;
    if (grant_seq.size() != 4) begin bad++; $display("FAIL rr_count got=%0d expected=4", grant_seq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grant_seq[i] != exp_seq[i])
          begin bad++; $display("FAIL rr_grant[%0d] got=%0d expected=%0d", i, grant_seq[i], exp_seq[i]); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      total++;
      if (W_Sel !== 2'(exp_seq[i]) || W_Sel_valid !== 1'b1)
        begin bad++; $display("FAIL rr_wsel[%0d] got=%0d/%b expected=%0d/1", i, W_Sel, W_Sel_valid, exp_seq[i]); end
      W_last_hs = 1'b1; advance(); W_last_hs = 1'b0;
    end
  endtask

  task automatic test_fifo_full();
    int waited;
    apply_reset();
    S00_AXI_awvalid = 1'b1; S00_AXI_awqos = 4'd3;
    S01_AXI_awvalid = 1'b1; S01_AXI_awqos = 4'd3;
    M_AXI_awready = 1'b1;
    collect_grants(4, 20, 1'b0);
    total++;
    if (grant_seq.size() != 4) begin bad++; $display("FAIL full_accepted got=%0d expected=4", grant_seq.size()); end
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      total++;
      if (Grant_valid !== 1'b0 || S00_AXI_awready !== 1'b0 || S01_AXI_awready !== 1'b0)
        begin bad++; $display("FAIL full_blocked gv=%b r0=%b r1=%b expected 0 0 0",
          Grant_valid, S00_AXI_awready, S01_AXI_awready); end
      advance();
    end
    W_last_hs = 1'b1; advance(); W_last_hs = 1'b0;
    @(negedge ACLK);
    total++;
    if (W_Sel !== 2'd1) begin bad++; $display("FAIL full_pop_advance wsel=%0d expected=1", W_Sel); end
    waited = 0;
    while (!Grant_valid && waited < 2) begin
      advance();
      @(negedge ACLK);
      waited++;
    end
    total++;
    if (Grant_valid !== 1'b1 || Selected_Slave !== 2'd0)
      begin bad++; $display("FAIL full_fifth_grant gv=%b sel=%0d expected 1 0", Grant_valid, Selected_Slave); end
    clear_inputs();
  endtask

  task automatic test_stall();
    apply_reset();
    S00_AXI_awvalid = 1'b1; M_AXI_awready = 1'b0;
    advance();
    S01_AXI_awvalid = 1'b1; S01_AXI_awqos = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      total++;
      if (Grant_valid !== 1'b1 || Selected_Slave !== 2'd0 || S01_AXI_awready !== 1'b0 || S00_AXI_awready !== 1'b0)
        begin bad++; $display("FAIL stall_hold[%0d] gv=%b sel=%0d r0=%b r1=%b expected 1 0 0 0",
          i, Grant_valid, Selected_Slave, S00_AXI_awready, S01_AXI_awready); end
      advance();
    end
    M_AXI_awready = 1'b1;
    @(negedge ACLK);
    total++;
    if (S00_AXI_awready !== 1'b1) begin bad++; $display("FAIL stall_ready got=%b expected=1", S00_AXI_awready); end
    advance();
    S00_AXI_awvalid = 1'b0;
    advance();
    @(negedge ACLK);
    total++;
    if (Grant_valid !== 1'b1 || Selected_Slave !== 2'd1 || S01_AXI_awready !== 1'b1)
      begin bad++; $display("FAIL stall_next gv=%b sel=%0d r1=%b expected 1 1 1",
        Grant_valid, Selected_Slave, S01_AXI_awready); end
    clear_inputs();
  endtask

  task automatic test_order_err_and_async_reset();
    apply_reset();
    W_last_hs = 1'b1; advance(); W_last_hs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      total++;
      if (Order_err !== 1'b1 || W_Sel_valid !== 1'b0)
        begin bad++; $display("FAIL order_err_sticky[%0d] err=%b wsv=%b expected 1 0", i, Order_err, W_Sel_valid); end
      advance();
    end
    // Put one entry in the FIFO, then open a second grant that stays pending.
    S00_AXI_awvalid = 1'b1; M_AXI_awready = 1'b1;
    advance(); advance();
    M_AXI_awready = 1'b0;
    advance();
    @(negedge ACLK);
    total++;
    if (Grant_valid !== 1'b1 || W_Sel_valid !== 1'b1)
      begin bad++; $display("FAIL async_pre gv=%b wsv=%b expected 1 1", Grant_valid, W_Sel_valid); end
    #1 M_AXI_awready = 1'b1;
    #1;
    total++;
    if (S00_AXI_awready !== 1'b1) begin bad++; $display("FAIL async_pre_ready got=%b expected=1", S00_AXI_awready); end
    #1 ARESETN = 1'b0;
    model_reset();
    #1;
    total++;
    if ({Selected_Slave, Grant_valid, S00_AXI_awready, S01_AXI_awready, W_Sel, W_Sel_valid, Order_err} !== 9'd0)
      begin bad++; $display("FAIL async_reset got=%b expected=%b",
        {Selected_Slave, Grant_valid, S00_AXI_awready, S01_AXI_awready, W_Sel, W_Sel_valid, Order_err}, 9'd0); end
    apply_reset();
  endtask

  task automatic test_random();
    bit         exp_gv;
    logic [1:0] exp_sel;
    bit         exp_r0;
    bit         exp_r1;
    bit         exp_wv;
    logic [1:0] exp_ws;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      S00_AXI_awvalid = ($urandom_range(0, 3) != 0);
      S01_AXI_awvalid = ($urandom_range(0, 3) != 0);
      S00_AXI_awqos   = 4'($urandom_range(0, 3));
      S01_AXI_awqos   = 4'($urandom_range(0, 3));
      M_AXI_awready   = ($urandom_range(0, 9) < 7);
      W_last_hs       = ($urandom_range(0, 3) == 0);
      @(negedge ACLK);
      exp_gv  = m_granted;
      exp_sel = {1'b0, m_sel};
      exp_r0  = m_granted && !m_sel && M_AXI_awready;
      exp_r1  = m_granted &&  m_sel && M_AXI_awready;
      exp_wv  = (m_q.size() != 0);
      exp_ws  = exp_wv ? 2'(m_q[0]) : 2'd0;
      total++;
      if (Grant_valid !== exp_gv) begin bad++; $display("FAIL rnd_gv c=%0d got=%b expected=%b", c, Grant_valid, exp_gv); end
      total++;
      if (exp_gv && Selected_Slave !== exp_sel)
        begin bad++; $display("FAIL rnd_sel c=%0d got=%0d expected=%0d", c, Selected_Slave, exp_sel); end
      total++;
      if (S00_AXI_awready !== exp_r0 || S01_AXI_awready !== exp_r1)
        begin bad++; $display("FAIL rnd_awready c=%0d got=%b%b expected=%b%b", c,
          S00_AXI_awready, S01_AXI_awready, exp_r0, exp_r1); end
      total++;
      if (W_Sel_valid !== exp_wv || W_Sel !== exp_ws)
        begin bad++; $display("FAIL rnd_wsel c=%0d got=%0d/%b expected=%0d/%b", c, W_Sel, W_Sel_valid, exp_ws, exp_wv); end
      total++;
      if (Order_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b expected=%b", c, Order_err, m_err); end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_qos();
    test_round_robin();
    test_fifo_full();
    test_stall();
    test_order_err_and_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
